// File: rtl/dll_lock_monitor.sv
// DLL lock monitor: qualifies SAR delay codes against a reference and declares or drops lock.
// Optional watchdog enabled by defining DLL_LKD_TIMEOUT_EN; default build has no watchdog.
module dll_lock_monitor #(
    parameter int LOCK_CNT = 8,
    parameter int TOL      = 2,
    parameter int TIMEOUT  = 1024
) (
    input  logic       clk_ext,
    input  logic       rst,
    input  logic       en,
    input  logic       code_valid,
    input  logic [9:0] code_in,
    output logic [9:0] code_out,
    output logic       lock,
    output logic       lock_lost,
    output logic       timeout,
    output logic [1:0] state
);

    // state   | meaning
    // ST_IDLE | monitor disabled or waiting for first code
    // ST_ACQ  | counting consecutive in-tolerance codes
    // ST_LOCK | locked; in-tolerance codes are frozen out
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACQ  = 2'b01,
        ST_LOCK = 2'b10
    } state_t;

    if (LOCK_CNT < 2 || LOCK_CNT > 255) begin : g_bad_lock_cnt
        $error("LOCK_CNT out of range 2..255");
    end
    if (TOL < 0 || TOL > 1023) begin : g_bad_tol
        $error("TOL out of range 0..1023");
    end
    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("TIMEOUT out of range 2..65535");
    end

    state_t      state_q;
    logic [9:0]  code_ref_q;
    logic [9:0]  code_out_q;
    logic [7:0]  cnt_q;
    logic        lock_q;
    logic        lock_lost_q;

    logic [10:0] delta_d;
    logic        in_tol_d;
    logic [7:0]  cnt_d;
    logic        reach_lock_d;

    // 11-bit unsigned difference so 0 vs 1023 yields 1023, not a wrapped 1
    always_comb begin
        delta_d = 11'd0;
        if (code_in >= code_ref_q) begin
            delta_d = {1'b0, code_in} - {1'b0, code_ref_q};
        end else begin
            delta_d = {1'b0, code_ref_q} - {1'b0, code_in};
        end
    end

    assign in_tol_d     = (delta_d <= 11'(TOL));
    assign cnt_d        = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    assign reach_lock_d = (({1'b0, cnt_q} + 9'd1) == 9'(LOCK_CNT));

`ifdef DLL_LKD_TIMEOUT_EN
    logic [15:0] wdog_q;
    logic        timeout_q;
    logic        wdog_exp_d;

    assign wdog_exp_d = (wdog_q == 16'(TIMEOUT - 1));
`endif

    always_ff @(posedge clk_ext or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            code_ref_q  <= 10'd0;
            code_out_q  <= 10'd0;
            cnt_q       <= 8'd0;
            lock_q      <= 1'b0;
            lock_lost_q <= 1'b0;
`ifdef DLL_LKD_TIMEOUT_EN
            wdog_q      <= 16'd0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            lock_lost_q <= 1'b0;
`ifdef DLL_LKD_TIMEOUT_EN
            timeout_q   <= 1'b0;
`endif
            if (!en) begin
                state_q <= ST_IDLE;
                lock_q  <= 1'b0;
                cnt_q   <= 8'd0;
`ifdef DLL_LKD_TIMEOUT_EN
                wdog_q  <= 16'd0;
`endif
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (code_valid) begin
                            code_ref_q <= code_in;
                            code_out_q <= code_in;
                            cnt_q      <= 8'd1;
                            state_q    <= ST_ACQ;
`ifdef DLL_LKD_TIMEOUT_EN
                            wdog_q     <= 16'd0;
`endif
                        end
                    end
                    ST_ACQ: begin
                        if (code_valid) begin
                            code_out_q <= code_in;
`ifdef DLL_LKD_TIMEOUT_EN
                            wdog_q     <= 16'd0;
`endif
                            if (in_tol_d) begin
                                cnt_q <= cnt_d;
                                if (reach_lock_d) begin
                                    state_q <= ST_LOCK;
                                    lock_q  <= 1'b1;
                                end
                            end else begin
                                code_ref_q <= code_in;
                                cnt_q      <= 8'd1;
                            end
                        end
`ifdef DLL_LKD_TIMEOUT_EN
                        else if (wdog_exp_d) begin
                            state_q   <= ST_IDLE;
                            timeout_q <= 1'b1;
                            lock_q    <= 1'b0;
                            cnt_q     <= 8'd0;
                            wdog_q    <= 16'd0;
                        end else begin
                            wdog_q <= wdog_q + 16'd1;
                        end
`endif
                    end
                    ST_LOCK: begin
                        if (code_valid) begin
`ifdef DLL_LKD_TIMEOUT_EN
                            wdog_q <= 16'd0;
`endif
                            // in-tolerance codes leave code_out/code_ref frozen
                            if (!in_tol_d) begin
                                lock_q      <= 1'b0;
                                lock_lost_q <= 1'b1;
                                code_ref_q  <= code_in;
                                code_out_q  <= code_in;
                                cnt_q       <= 8'd1;
                                state_q     <= ST_ACQ;
                            end
                        end
`ifdef DLL_LKD_TIMEOUT_EN
                        else if (wdog_exp_d) begin
                            state_q   <= ST_IDLE;
                            timeout_q <= 1'b1;
                            lock_q    <= 1'b0;
                            cnt_q     <= 8'd0;
                            wdog_q    <= 16'd0;
                        end else begin
                            wdog_q <= wdog_q + 16'd1;
                        end
`endif
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        lock_q  <= 1'b0;
                        cnt_q   <= 8'd0;
                    end
                endcase
            end
        end
    end

    assign code_out  = code_out_q;
    assign lock      = lock_q;
    assign lock_lost = lock_lost_q;
    assign state     = state_q;
`ifdef DLL_LKD_TIMEOUT_EN
    assign timeout   = timeout_q;
`else
    assign timeout   = 1'b0;
`endif

endmodule

// File: doc/dll_lock_monitor.md
DLL_LOCK_MONITOR -- requirements
Module: dll_lock_monitor

Interface
REQ-001 Parameter LOCK_CNT, default 8, meaning consecutive in-tolerance codes required to declare lock; legal range 2..255.
REQ-002 Parameter TOL, default 2, meaning maximum |code_in - code_ref| counted as in-tolerance; legal range 0..1023.
REQ-003 Parameter TIMEOUT, default 1024, meaning clk_ext cycles without code_valid before timeout; legal range 2..65535.
REQ-004 clk_ext  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  monitor enable; low forces IDLE.
REQ-007 code_valid  input  1  one-cycle strobe: code_in carries a new 10-bit SAR delay code.
REQ-008 code_in  input  10  SAR delay-line code from the phase-tuning controller.
REQ-009 code_out  output  10  registered code applied to the delay line.
REQ-010 lock  output  1  high while in LOCK state.
REQ-011 lock_lost  output  1  one-cycle pulse on LOCK->ACQ exit.
REQ-012 timeout  output  1  one-cycle pulse on watchdog expiry.
REQ-013 state  output  2  current FSM state: IDLE=00, ACQ=01, LOCK=10; 11 unused.

Function
REQ-014 All outputs SHALL be registered; a code_valid in cycle n SHALL affect outputs in cycle n+1.
REQ-015 delta SHALL be |code_in - code_ref|, computed unsigned at 11 bits with no wrap-around (0 vs 1023 gives delta 1023).
REQ-016 IDLE, en=1, code_valid=1: code_ref and code_out SHALL load code_in, cnt SHALL load 1, and the FSM SHALL go to ACQ.
REQ-017 ACQ, code_valid=1: code_out SHALL load code_in in every case.
REQ-018 ACQ, code_valid=1, delta<=TOL: cnt SHALL increment; when cnt+1 equals LOCK_CNT, the FSM SHALL go to LOCK and lock SHALL rise.
REQ-019 ACQ, code_valid=1, delta>TOL: code_ref SHALL load code_in, cnt SHALL load 1, and the FSM SHALL stay in ACQ.
REQ-020 LOCK, code_valid=1, delta<=TOL: code_out and code_ref SHALL hold (hysteresis freeze).
REQ-021 LOCK, code_valid=1, delta>TOL: lock SHALL fall, lock_lost SHALL pulse, code_ref and code_out SHALL load code_in, cnt SHALL load 1, and the FSM SHALL go to ACQ.
REQ-022 cnt SHALL be 8 bits and SHALL saturate, never wrapping.
REQ-023 en=0 in any state SHALL force IDLE next cycle, with lock=0, cnt=0, watchdog=0, code_out held, and no lock_lost pulse; en has priority over code_valid.
REQ-024 code_valid without en in IDLE SHALL be ignored.
REQ-025 lock_lost and timeout SHALL never be high for more than one consecutive cycle.

Reset
REQ-026 rst high SHALL asynchronously force state=IDLE, code_out=0, code_ref=0, cnt=0, lock=0, lock_lost=0, timeout=0, watchdog=0.
REQ-027 rst asserted mid-ACQ or mid-LOCK SHALL discard all progress; after release the FSM SHALL require a fresh IDLE->ACQ entry.
REQ-028 The first update after rst deassertion SHALL be on the next rising clk_ext edge.

Configuration
REQ-029 Macro DLL_LKD_TIMEOUT_EN defined: a 16-bit watchdog SHALL count cycles in ACQ or LOCK and clear on every code_valid.
REQ-030 Watchdog reaching TIMEOUT-1 with no code_valid: the FSM SHALL go to IDLE, timeout SHALL pulse, lock SHALL fall, code_out SHALL hold, and lock_lost SHALL NOT pulse.
REQ-031 code_valid in the expiry cycle SHALL take priority over timeout.
REQ-032 Macro DLL_LKD_TIMEOUT_EN undefined: no watchdog SHALL be built, timeout SHALL be constant 0, and ACQ and LOCK SHALL wait indefinitely.

Verification
REQ-033 Reset then en=1, codes 500,501,499,500,502,500,501,500 (LOCK_CNT=8, TOL=2) -> lock rises the cycle after the 8th strobe; code_out=500.
REQ-034 In LOCK, code 502 -> code_out stays 500; then code 510 -> lock_lost pulses, code_out=510, state=ACQ.
REQ-035 ACQ at code_ref=0, strobe 1023 -> delta=1023 (no wrap), cnt=1, code_ref=1023.
REQ-036 With DLL_LKD_TIMEOUT_EN and TIMEOUT=16, locked and then no strobe for 16 cycles -> timeout pulses once, state=IDLE, code_out held; a strobe at cycle 15 instead -> no timeout.
REQ-037 en=0 and code_valid=1 in the same cycle while locked -> IDLE next cycle, lock=0, no lock_lost, code_out unchanged.
REQ-038 rst asserted mid-clock while in LOCK -> all outputs 0 immediately, without waiting for an edge.
